cross_clock_bus_filter: RTL
===========================

CROSS_CLOCK_BUS_FILTER -- requirements
Module: cross_clock_bus_filter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one channel word.
REQ-002 Parameter CHANNELS, default 4: number of independent channels; legal 1..32.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flop depth per channel; legal 2..4.
REQ-004 Parameter STABLE_CYCLES, default 2: consecutive equal-sample comparisons required before a value is accepted; legal 1..255.
REQ-005 Parameter TIMEOUT_CYCLES, default 256: cycles of unresolved pending change before the unstable flag is raised; legal 2..65535.
REQ-006 out_clk  input  1: the block's only clock; all state is clocked on the rising edge.
REQ-007 rst  input  1: reset; asynchronous, active-high.
REQ-008 in_data  input  CHANNELS*DATA_WIDTH: asynchronous source data; channel n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-009 out_data  output  CHANNELS*DATA_WIDTH: registered accepted values, same packing as in_data.
REQ-010 out_update  output  CHANNELS: one-cycle pulse per channel, asserted in the cycle its out_data word changes.
REQ-011 out_valid  output  CHANNELS: per-channel flag; set at first acceptance after reset.
REQ-012 out_unstable  output  CHANNELS: per-channel stuck-input flag; see Configuration.

Function
REQ-013 Each channel has a SYNC_STAGES-deep flop chain s[0..SYNC_STAGES-1]; s[0] samples in_data each edge. No logic sits between stages.
REQ-014 Each channel has a prev register (prev <= s_last every edge) and a run counter cnt, saturating at STABLE_CYCLES.
REQ-015 On each edge: if s_last == prev, cnt <= min(cnt+1, STABLE_CYCLES); otherwise cnt <= 0.
REQ-016 Accept condition: s_last == prev and cnt >= STABLE_CYCLES-1.
REQ-017 On an edge with accept and (s_last != out_data word or out_valid == 0): out_data word <= s_last, out_update <= 1, out_valid <= 1; otherwise out_update <= 0 and out_data holds.
REQ-018 Latency: with in_data steady from the edge where s[0] first captures a new value (edge 1), out_data updates on edge SYNC_STAGES+STABLE_CYCLES+1 (edge 5 at defaults).
REQ-019 A value steady indefinitely produces exactly one out_update pulse; re-accepting an equal value produces none.
REQ-020 An input changing at least once every STABLE_CYCLES+1 cycles is never accepted; out_data holds its last accepted value.
REQ-021 Channels are fully independent; acceptance on one channel never affects another, including simultaneous acceptance on all channels.
REQ-022 out_valid, once set, clears only on reset.

Reset
REQ-023 Asserting rst asynchronously clears s chains, prev, cnt, out_data, out_update, out_valid, out_unstable and all timers to zero, including mid-acceptance.
REQ-024 After rst deasserts, a steady input of zero is still accepted (out_valid 0 -> 1 with one out_update pulse) at the REQ-018 latency.

Configuration
REQ-025 Macro CROSS_CLOCK_BUS_FILTER_STUCK_DETECT_EN compiles in a per-channel timer of width clog2(TIMEOUT_CYCLES+1).
REQ-026 With the macro: timer increments each edge where s_last != out_data word or out_valid == 0, saturating at TIMEOUT_CYCLES; timer clears on any accept edge or when s_last == out_data word with out_valid == 1.
REQ-027 With the macro: out_unstable sets on the edge the timer reaches TIMEOUT_CYCLES and stays set until the next accept edge for that channel or reset.
REQ-028 Without the macro: no timer logic; out_unstable is tied to zero; the port list is unchanged.

Verification
REQ-029 Defaults; reset, then ch0 = 8'hA5 steady -> out_data[7:0] = 8'hA5 on edge 5, single out_update[0] pulse, out_valid[0] = 1.
REQ-030 ch1 toggles 8'h00/8'hFF every 2 cycles for 1000 cycles -> out_data[15:8] unchanged, no out_update[1]; with macro, out_unstable[1] = 1 by cycle 257+latency.
REQ-031 All 4 channels change to distinct values on the same edge -> all out_update bits pulse together on edge 5; all words correct.
REQ-032 rst asserted asynchronously between edges 3 and 4 of an acceptance -> outputs zero immediately; after release, value accepted on edge 5 of the new sequence.
REQ-033 SYNC_STAGES=3, STABLE_CYCLES=1, input 8'h3C -> update on edge 5; same value re-held for 100 cycles -> no further pulses.

Source files
------------

// File: rtl/cross_clock_bus_filter.sv
// Purpose: per-channel synchroniser and stability filter for an asynchronous multi-channel bus.
// Latency: a steady new value appears on out_data SYNC_STAGES+STABLE_CYCLES+1 edges after s[0] captures it.
// Backpressure: none; outputs are registered level values plus a one-cycle update pulse per channel.
// Optional feature: define CROSS_CLOCK_BUS_FILTER_STUCK_DETECT_EN to build the per-channel stuck-input timer.
module cross_clock_bus_filter #(
    parameter int DATA_WIDTH     = 8,
    parameter int CHANNELS       = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           out_clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]            out_update,
    output logic [CHANNELS-1:0]            out_valid,
    output logic [CHANNELS-1:0]            out_unstable
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int FW = $clog2(SYNC_STAGES + 2);
    localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES + 1);

    // Right after reset the sync chain and prev hold cleared flops, not samples.
    // Comparisons only count once both s_last and prev carry real samples, so a
    // post-reset value (zero included) is accepted at the normal latency.
    logic [FW-1:0] r_fill;
    logic          w_cmp_en;

    assign w_cmp_en = (r_fill == FILL_DONE);

    // Count edges since reset until the sampling pipeline is primed.
    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
        end else if (r_fill != FILL_DONE) begin
            r_fill <= r_fill + FW'(1);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
        logic [DATA_WIDTH-1:0] r_prev;
        logic [CW-1:0]         r_cnt;
        logic [DATA_WIDTH-1:0] r_out;
        logic                  r_upd;
        logic                  r_vld;
        logic [DATA_WIDTH-1:0] w_in;
        logic [DATA_WIDTH-1:0] w_slast;
        logic                  w_same;
        logic                  w_accept;
        logic                  w_differs;

        assign w_in      = in_data[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_slast   = r_sync[SYNC_STAGES-1];
        assign w_same    = w_cmp_en && (w_slast == r_prev);
        assign w_accept  = w_same && (r_cnt >= CW'(STABLE_CYCLES - 1));
        assign w_differs = (w_slast != r_out) || !r_vld;

        // Plain flop chain: no logic between stages.
        always_ff @(posedge out_clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    r_sync[i] <= '0;
                end
            end else begin
                r_sync[0] <= w_in;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    r_sync[i] <= r_sync[i-1];
                end
            end
        end

        // Track the previous synchronised sample and the saturating run length.
        always_ff @(posedge out_clk or posedge rst) begin
            if (rst) begin
                r_prev <= '0;
                r_cnt  <= '0;
            end else begin
                r_prev <= w_slast;
                if (!w_same) begin
                    r_cnt <= '0;
                end else if (r_cnt != CW'(STABLE_CYCLES)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end

        // Load a newly accepted value and pulse update only when the word changes or is first valid.
        always_ff @(posedge out_clk or posedge rst) begin
            if (rst) begin
                r_out <= '0;
                r_upd <= 1'b0;
                r_vld <= 1'b0;
            end else if (w_accept && w_differs) begin
                r_out <= w_slast;
                r_upd <= 1'b1;
                r_vld <= 1'b1;
            end else begin
                r_upd <= 1'b0;
            end
        end

        assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = r_out;
        assign out_update[c] = r_upd;
        assign out_valid[c]  = r_vld;

`ifdef CROSS_CLOCK_BUS_FILTER_STUCK_DETECT_EN
        localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
        logic [TW-1:0] r_timer;
        logic          r_uns;

        // Age an unresolved pending change; any accept or a settled match restarts it.
        always_ff @(posedge out_clk or posedge rst) begin
            if (rst) begin
                r_timer <= '0;
            end else if (w_accept || !w_differs) begin
                r_timer <= '0;
            end else if (r_timer != TW'(TIMEOUT_CYCLES)) begin
                r_timer <= r_timer + TW'(1);
            end
        end

        // Flag sets as the timer reaches its limit and holds until the next accept.
        always_ff @(posedge out_clk or posedge rst) begin
            if (rst) begin
                r_uns <= 1'b0;
            end else if (w_accept) begin
                r_uns <= 1'b0;
            end else if (w_differs && (r_timer == TW'(TIMEOUT_CYCLES - 1))) begin
                r_uns <= 1'b1;
            end
        end

        assign out_unstable[c] = r_uns;
`else
        assign out_unstable[c] = 1'b0;
`endif
    end

endmodule
